// File: rtl/prbs7_checker_if.sv
// prbs7_checker_if
//   Bundles the serial input and the status/count outputs of the PRBS-7 checker.
//   clock and reset stay plain ports on the checker itself.
//   i_din        received serial bit
//   i_din_valid  i_din is meaningful this cycle (no backpressure)
//   i_clr_cnt    synchronous clear of the bit/error counters
//   o_locked     checker is locked to the PRBS-7 stream
//   o_err_pulse  one-cycle pulse for a mismatched bit seen while locked
//   o_bit_cnt    bits checked while locked (saturating)
//   o_err_cnt    mismatched bits while locked (saturating)
//   Modports: master = stream source / status consumer, slave = checker.
interface prbs7_checker_if #(
   parameter int CNT_W = 32
);
   logic             i_din;
   logic             i_din_valid;
   logic             i_clr_cnt;
   logic             o_locked;
   logic             o_err_pulse;
   logic [CNT_W-1:0] o_bit_cnt;
   logic [CNT_W-1:0] o_err_cnt;

   modport master (
      output i_din, i_din_valid, i_clr_cnt,
      input  o_locked, o_err_pulse, o_bit_cnt, o_err_cnt
   );

   modport slave (
      input  i_din, i_din_valid, i_clr_cnt,
      output o_locked, o_err_pulse, o_bit_cnt, o_err_cnt
   );
endinterface

// File: rtl/prbs7_checker.sv
// prbs7_checker
//   Receive-side PRBS-7 (x^7+x^6+1) checker. Self-synchronises a local LFSR to
//   the incoming serial stream (SEED -> VERIFY -> LOCKED), then flywheels the
//   LFSR and counts checked bits and bit errors for BER measurement.
//   A tumbling window of WIN_LEN valid bits watches for LOSS_THRESH errors.
// Ports
//   i_clock  sole clock, posedge
//   i_reset  synchronous, active-high
//   bus      prbs7_checker_if.slave (din/valid/clr in, locked/pulse/counts out)
// Configuration
//   PRBS7_RELOCK_EN  defined: loss of lock returns to SEED and reacquires.
//                    undefined: loss condition ignored, stays LOCKED until reset.
module prbs7_checker #(
   parameter int LOCK_CNT    = 16,
   parameter int CNT_W       = 32,
   parameter int WIN_LEN     = 128,
   parameter int LOSS_THRESH = 8
) (
   input  logic           i_clock,
   input  logic           i_reset,
   prbs7_checker_if.slave bus
);

   localparam int MW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT);
   localparam int WB = $clog2(WIN_LEN + 1);

   typedef enum logic [1:0] {ST_SEED, ST_VERIFY, ST_LOCKED} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [6:0]       r_s;
   logic [2:0]       r_seed_cnt;
   logic [MW-1:0]    r_match_cnt;
   logic [WB-1:0]    r_win_bits;
   logic [WB-1:0]    r_win_errs;
   logic             r_locked;
   logic             r_err_pulse;
   logic [CNT_W-1:0] r_bit_cnt;
   logic [CNT_W-1:0] r_err_cnt;

   logic             w_vld;
   logic             w_pred;
   logic             w_mism;
   logic [6:0]       w_load;
   logic             w_seed_done;
   logic             w_lock_hit;
   logic [WB-1:0]    w_win_errs_inc;
   logic             w_loss;
   logic             w_win_end;
   logic             w_relock;
   logic             w_cnt_inc;

   assign w_vld          = bus.i_din_valid;
   assign w_pred         = r_s[6] ^ r_s[5];
   assign w_mism         = bus.i_din ^ w_pred;
   assign w_load         = {r_s[5:0], bus.i_din};
   assign w_seed_done    = (r_seed_cnt == 3'd6);
   assign w_lock_hit     = (r_match_cnt == MW'(LOCK_CNT - 1));
   assign w_win_errs_inc = r_win_errs + WB'(w_mism);
   // Loss fires only on the error that brings the window count to the threshold.
   assign w_loss         = w_mism && (w_win_errs_inc == WB'(LOSS_THRESH));
   assign w_win_end      = (r_win_bits == WB'(WIN_LEN - 1));
   assign w_cnt_inc      = w_vld && (r_state == ST_LOCKED);

`ifdef PRBS7_RELOCK_EN
   assign w_relock = w_loss;
`else
   assign w_relock = 1'b0;
`endif

   // state register
   always_ff @(posedge i_clock) begin
      if (i_reset) r_state <= ST_SEED;
      else         r_state <= w_state_nxt;
   end

   // next state
   always_comb begin
      w_state_nxt = r_state;
      if (w_vld) begin
         unique case (r_state)
            ST_SEED: begin
               // an all-zero seed would lock the LFSR at zero; keep seeding
               if (w_seed_done && (w_load != 7'd0)) w_state_nxt = ST_VERIFY;
            end
            ST_VERIFY: begin
               if (w_mism)          w_state_nxt = ST_SEED;
               else if (w_lock_hit) w_state_nxt = ST_LOCKED;
            end
            ST_LOCKED: begin
               if (w_relock) w_state_nxt = ST_SEED;
            end
            default: w_state_nxt = ST_SEED;
         endcase
      end
   end

   // LFSR, acquisition and window counters
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_s         <= '0;
         r_seed_cnt  <= '0;
         r_match_cnt <= '0;
         r_win_bits  <= '0;
         r_win_errs  <= '0;
         r_locked    <= 1'b0;
         r_err_pulse <= 1'b0;
      end else begin
         r_locked    <= (w_state_nxt == ST_LOCKED);
         r_err_pulse <= 1'b0;
         if (w_vld) begin
            unique case (r_state)
               ST_SEED: begin
                  r_s         <= w_load;
                  r_match_cnt <= '0;
                  r_seed_cnt  <= w_seed_done ? 3'd0 : r_seed_cnt + 3'd1;
               end
               ST_VERIFY: begin
                  r_s <= w_load;
                  if (w_mism) begin
                     r_seed_cnt  <= '0;
                     r_match_cnt <= '0;
                  end else if (w_lock_hit) begin
                     r_match_cnt <= '0;
                     r_win_bits  <= '0;
                     r_win_errs  <= '0;
                  end else begin
                     r_match_cnt <= r_match_cnt + MW'(1);
                  end
               end
               ST_LOCKED: begin
                  // flywheel: feed back the prediction so line errors never enter the LFSR
                  r_s         <= {r_s[5:0], w_pred};
                  r_err_pulse <= w_mism;
                  if (w_relock || w_win_end) begin
                     r_win_bits <= '0;
                     r_win_errs <= '0;
                  end else begin
                     r_win_bits <= r_win_bits + WB'(1);
                     r_win_errs <= w_win_errs_inc;
                  end
                  if (w_relock) r_seed_cnt <= '0;
               end
               default: ;
            endcase
         end
      end
   end

   // BER counters: saturating, clear wins over a same-cycle increment
   always_ff @(posedge i_clock) begin
      if (i_reset || bus.i_clr_cnt) begin
         r_bit_cnt <= '0;
         r_err_cnt <= '0;
      end else if (w_cnt_inc) begin
         if (r_bit_cnt != '1)          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
         if (w_mism && r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
   end

   assign bus.o_locked    = r_locked;
   assign bus.o_err_pulse = r_err_pulse;
   assign bus.o_bit_cnt   = r_bit_cnt;
   assign bus.o_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_prbs7_checker.sv
// Bench for prbs7_checker: two DUTs (CNT_W=32 and CNT_W=4) share one stimulus
// stream and are compared every cycle against a queue-based reference model.
module tb_prbs7_checker;
   localparam int LOCK_CNT    = 16;
   localparam int WIN_LEN     = 128;
   localparam int LOSS_THRESH = 8;

   logic clk = 1'b0;
   logic rst = 1'b0, din = 1'b0, vld = 1'b0, clr = 1'b0;
   always #5 clk = ~clk;

   prbs7_checker_if #(.CNT_W(32)) bus32();
   prbs7_checker_if #(.CNT_W(4))  bus4();
   assign bus32.i_din = din; assign bus32.i_din_valid = vld; assign bus32.i_clr_cnt = clr;
   assign bus4.i_din  = din; assign bus4.i_din_valid  = vld; assign bus4.i_clr_cnt  = clr;

   prbs7_checker #(.LOCK_CNT(LOCK_CNT), .CNT_W(32), .WIN_LEN(WIN_LEN), .LOSS_THRESH(LOSS_THRESH))
      u_dut32 (.i_clock(clk), .i_reset(rst), .bus(bus32.slave));
   prbs7_checker #(.LOCK_CNT(LOCK_CNT), .CNT_W(4), .WIN_LEN(WIN_LEN), .LOSS_THRESH(LOSS_THRESH))
      u_dut4 (.i_clock(clk), .i_reset(rst), .bus(bus4.slave));

   int total = 0, bad = 0;
   bit chk_en = 1'b0;

   function automatic void chk(string nm, longint act, longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
      end
   endfunction

   function automatic longint sat(longint x, int w);
      longint m = (longint'(1) << w) - 1;
      return (x > m) ? m : x;
   endfunction

   // ---------------- reference model ----------------
   bit     mq[$];      // last 7 reference bits (received while acquiring, predicted while locked)
   int     acq;        // clean valid bits since acquisition restart
   bit     m_locked, m_pulse;
   longint m_bits, m_errs;
   int     wb, we;

   task automatic push_ref(input bit b);
      mq.push_back(b);
      if (mq.size() > 7) void'(mq.pop_front());
   endtask

   task automatic model_step(input bit r, input bit v, input bit d, input bit c);
      bit bad_bit, p, e;
      int ones;
      if (r) begin
         mq.delete(); acq = 0; m_locked = 0; m_pulse = 0;
         m_bits = 0; m_errs = 0; wb = 0; we = 0;
         return;
      end
      m_pulse = 0;
      if (v) begin
         if (!m_locked) begin
            bad_bit = (acq >= 7) && (d != (mq[0] ^ mq[1]));
            push_ref(d);
            if (bad_bit) acq = 0;
            else begin
               acq++;
               ones = 0;
               foreach (mq[i]) ones += int'(mq[i]);
               if (acq == 7 && ones == 0) acq = 0;
               else if (acq == 7 + LOCK_CNT) begin m_locked = 1; wb = 0; we = 0; end
            end
         end else begin
            p = mq[0] ^ mq[1];
            e = (d != p);
            push_ref(p);
            m_bits++;
            if (e) m_errs++;
            m_pulse = e;
            wb++;
            if (e) we++;
`ifdef PRBS7_RELOCK_EN
            if (e && we == LOSS_THRESH) begin
               m_locked = 0; acq = 0; wb = 0; we = 0;
            end else
`endif
            if (wb == WIN_LEN) begin wb = 0; we = 0; end
         end
      end
      if (c) begin m_bits = 0; m_errs = 0; end
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) if (chk_en) begin
      chk("locked",    longint'(bus32.o_locked),    longint'(m_locked));
      chk("locked4",   longint'(bus4.o_locked),     longint'(m_locked));
      chk("err_pulse", longint'(bus32.o_err_pulse), longint'(m_pulse));
      chk("bit_cnt",   longint'(bus32.o_bit_cnt),   sat(m_bits, 32));
      chk("err_cnt",   longint'(bus32.o_err_cnt),   sat(m_errs, 32));
      chk("bit_cnt4",  longint'(bus4.o_bit_cnt),    sat(m_bits, 4));
      chk("err_cnt4",  longint'(bus4.o_err_cnt),    sat(m_errs, 4));
   end

   // ---------------- stimulus ----------------
   bit gq[$];
   int gcnt = 0;
   // PRBS-7 source seeded with 7'h7F: seven ones, then b[n] = b[n-7]^b[n-6]
   task automatic gen(output bit b);
      b = (gcnt < 7) ? 1'b1 : (gq[0] ^ gq[1]);
      gq.push_back(b);
      if (gq.size() > 7) void'(gq.pop_front());
      gcnt++;
   endtask

   task automatic step(input bit r, input bit v, input bit d, input bit c);
      rst = r; vld = v; din = d; clr = c;
      @(posedge clk); #1;
      model_step(r, v, d, c);
   endtask

   task automatic clean_bit();
      bit b; gen(b); step(0, 1, b, 0);
   endtask

   task automatic err_bit();
      bit b; gen(b); step(0, 1, ~b, 0);
   endtask

   task automatic wait_lock(input bit gapped, output int n);
      n = 0;
      while (!bus32.o_locked && n < 200) begin
         if (gapped) begin step(0, 0, 0, 0); step(0, 0, 0, 0); end
         clean_bit();
         n++;
      end
   endtask

   initial begin
      int n;
      bit pulse_seen;
      bit r, v, d, c, e, b;
      step(1, 0, 0, 0);
      chk_en = 1'b1;
      // reset state
      chk("rst_locked", bus32.o_locked, 0);
      chk("rst_bitcnt", bus32.o_bit_cnt, 0);

      // clean stream: lock after 23 valid bits, then 100 counted bits
      wait_lock(0, n);
      chk("lock_point", n, 23);
      pulse_seen = 0;
      repeat (100) begin clean_bit(); pulse_seen |= bus32.o_err_pulse; end
      chk("bit_cnt_100", bus32.o_bit_cnt, 100);
      chk("err_cnt_0", bus32.o_err_cnt, 0);
      chk("no_pulse", pulse_seen, 0);
      chk("bit_cnt4_sat", bus4.o_bit_cnt, 15);

      // single flipped bit while locked: one pulse, flywheel keeps it clean after
      err_bit();
      chk("flip_pulse", bus32.o_err_pulse, 1);
      chk("flip_errcnt", bus32.o_err_cnt, 1);
      clean_bit();
      chk("flip_pulse_end", bus32.o_err_pulse, 0);
      chk("flip_locked", bus32.o_locked, 1);
      repeat (20) clean_bit();
      chk("flywheel_errcnt", bus32.o_err_cnt, 1);

      // error at the 10th VERIFY bit restarts acquisition
      step(1, 0, 0, 0);
      repeat (16) clean_bit();
      err_bit();
      chk("verify_fail_unlocked", bus32.o_locked, 0);
      wait_lock(0, n);
      chk("relock_after_flip", n, 23);

      // all-zero stream never locks
      step(1, 0, 0, 0);
      repeat (60) step(0, 1, 0, 0);
      chk("zero_no_lock", bus32.o_locked, 0);

      // 8 errors inside one window
      step(1, 0, 0, 0);
      wait_lock(0, n);
      chk("lock_point2", n, 23);
      for (int k = 0; k < 76; k++) begin
         if (k % 10 == 5) err_bit(); else clean_bit();
      end
      chk("loss_errcnt", bus32.o_err_cnt, 8);
`ifdef PRBS7_RELOCK_EN
      chk("loss_locked", bus32.o_locked, 0);
      wait_lock(0, n);
      chk("loss_relock", n, 23);
`else
      chk("loss_locked", bus32.o_locked, 1);
`endif

      // clear with a valid bit: clear wins
      gen(b);
      step(0, 1, b, 1);
      chk("clr_bitcnt", bus32.o_bit_cnt, 0);
      chk("clr_errcnt", bus32.o_err_cnt, 0);

      // gapped valid: same lock point in valid bits
      step(1, 0, 0, 0);
      wait_lock(1, n);
      chk("gapped_lock", n, 23);

      // reset while locked with nonzero counts and a pending pulse
      repeat (10) clean_bit();
      err_bit();
      step(1, 0, 0, 0);
      chk("rst2_locked", bus32.o_locked, 0);
      chk("rst2_pulse", bus32.o_err_pulse, 0);
      chk("rst2_bitcnt", bus32.o_bit_cnt, 0);
      chk("rst2_errcnt", bus32.o_err_cnt, 0);

      // randomized traffic: light then heavy error rates
      for (int i = 0; i < 4000; i++) begin
         r = ($urandom_range(0, 999) == 0);
         v = ($urandom_range(0, 3) != 0);
         e = (i < 2500) ? ($urandom_range(0, 79) == 0) : ($urandom_range(0, 9) == 0);
         c = ($urandom_range(0, 299) == 0);
         if (v) begin gen(b); d = b ^ e; end
         else d = 1'($urandom_range(0, 1));
         step(r, v, d, c);
      end

      vld = 0; clr = 0; rst = 0;
      @(posedge clk); #1;
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
